rr_mux_arbiter: RTL and testbench

Round-robin arbiter that shares one mux-based output channel among `N_REQ` valid/ready requesters. Each cycle it picks one requester, steers that requester's data through an N:1 mux tree built from the team's 2:1 `mux` cells, and captures it in a single output register stage. It sits in front of any shared single-port resource in the combinational-logic exercises and turns the plain mux datapath into a fair, back-pressured, sequenced channel.

---
 rtl/rr_mux_arbiter.sv | 149 ++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that steers one of N_REQ valid/ready requesters through a tree of 2:1 mux
// cells into a single registered output stage with back-pressure.

module mux #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

module rr_mux_arbiter #(
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDX_W-1:0]       out_grant,
    input  logic                   out_ready
);

    // Mux tree is built over a power-of-two leaf count; unused leaves are tied to zero.
    localparam int unsigned LEAVES = 1 << IDX_W;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic             load;
    logic             any_valid;
    logic [IDX_W-1:0] win;
    logic [WIDTH-1:0] leaf [LEAVES];
    logic [WIDTH-1:0] mux_out;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        int unsigned idx;
        logic [IDX_W-1:0] cand;
        any_valid = 1'b0;
        win       = last_q;
        idx       = 0;
        cand      = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx  = (32'(last_q) + off) % N_REQ;
            cand = IDX_W'(idx);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                win       = cand;
            end
        end
    end

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < N_REQ) begin : g_used
            assign leaf[i] = req_data[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign leaf[i] = '0;
        end
    end

    // Level l halves the candidates using win[l]; level 0 sits next to the leaves.
    for (genvar l = 0; l < IDX_W; l++) begin : g_lvl
        localparam int unsigned NSRC = LEAVES >> l;
        logic [WIDTH-1:0] src  [NSRC];
        logic [WIDTH-1:0] node [NSRC/2];

        for (genvar j = 0; j < NSRC; j++) begin : g_src
            if (l == 0) begin : g_from_leaf
                assign src[j] = leaf[j];
            end else begin : g_from_lvl
                assign src[j] = g_lvl[l-1].node[j];
            end
        end

        for (genvar j = 0; j < NSRC / 2; j++) begin : g_node
            mux #(
                .WIDTH(WIDTH)
            ) u_mux (
                .in0(src[2*j]),
                .in1(src[2*j+1]),
                .sel(win[l]),
                .out(node[j])
            );
        end
    end

    assign mux_out = g_lvl[IDX_W-1].node[0];

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        grant_d   = grant_q;
        last_d    = last_q;
        req_ready = '0;
        load      = (state_q == StEmpty) || out_ready;

        if (load) begin
            if (any_valid) begin
                state_d        = StFull;
                data_d         = mux_out;
                grant_d        = win;
                last_d         = win;
                req_ready[win] = 1'b1;
            end else begin
                state_d = StEmpty;
            end
        end

        // No handshake may complete in a cycle whose edge is a reset.
        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign out_grant = grant_q;

    req_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized bench for rr_mux_arbiter: requesters obey valid/ready, a cycle-level reference model
// predicts req_ready and the output register, and a wait counter bounds round-robin fairness.

module tb_rr_mux_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDX_W = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [IDX_W-1:0]       out_grant;
    logic                   out_ready;

    always #5 clk = ~clk;

    rr_mux_arbiter #(
        .N_REQ(N_REQ),
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_grant(out_grant),
        .out_ready(out_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state, as described behaviourally: pointer, output word, its source.
    int               m_last;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_grant;

    logic [WIDTH-1:0] rd [N_REQ];
    int               waits [N_REQ];
    logic [N_REQ-1:0] mask;
    int               p_valid, p_drop, p_ready, p_rst;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // First valid index scanning last+1, last+2, ... modulo N_REQ; -1 if none.
    function automatic int pick(input logic [N_REQ-1:0] v, input int last);
        for (int off = 1; off <= int'(N_REQ); off++) begin
            if (v[(last + off) % N_REQ]) return (last + off) % N_REQ;
        end
        return -1;
    endfunction

    task automatic step();
        int               win;
        logic             load;
        logic [N_REQ-1:0] exp_ready;
        for (int i = 0; i < int'(N_REQ); i++) req_data[i*WIDTH +: WIDTH] = rd[i];

        @(negedge clk);
        load      = !m_valid || out_ready;
        win       = pick(req_valid, m_last);
        exp_ready = '0;
        if (!rst && load && win >= 0) exp_ready[win] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_data", 32'(out_data), 32'(m_data));
        check_eq("out_grant", 32'(out_grant), 32'(m_grant));

        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_grant = 0;
            m_last  = N_REQ - 1;
            for (int i = 0; i < int'(N_REQ); i++) waits[i] = 0;
        end else if (load) begin
            if (win >= 0) begin
                check_eq("fair_wait", 32'(waits[win] <= int'(N_REQ) - 1), 32'd1);
                for (int i = 0; i < int'(N_REQ); i++) begin
                    if (i == win) waits[i] = 0;
                    else if (req_valid[i]) waits[i]++;
                end
                m_valid = 1'b1;
                m_data  = rd[win];
                m_grant = win;
                m_last  = win;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;

        for (int i = 0; i < int'(N_REQ); i++) begin
            if (exp_ready[i]) begin
                req_valid[i] = mask[i] && (int'($urandom_range(99)) < p_valid);
                rd[i]        = WIDTH'($urandom);
            end else if (req_valid[i]) begin
                if (int'($urandom_range(99)) < p_drop) begin
                    req_valid[i] = 1'b0;
                    waits[i]     = 0;
                end
            end else if (mask[i] && int'($urandom_range(99)) < p_valid) begin
                req_valid[i] = 1'b1;
                rd[i]        = WIDTH'($urandom);
            end
        end
        out_ready = (int'($urandom_range(99)) < p_ready);
        rst       = (int'($urandom_range(999)) < p_rst);
    endtask

    task automatic run_phase(input logic [N_REQ-1:0] m, input int pv, input int pd, input int pr,
                             input int prst, input int n);
        mask    = m;
        p_valid = pv;
        p_drop  = pd;
        p_ready = pr;
        p_rst   = prst;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!m[i]) begin
                req_valid[i] = 1'b0;
                waits[i]     = 0;
            end else if (!req_valid[i] && int'($urandom_range(99)) < pv) begin
                req_valid[i] = 1'b1;
                rd[i]        = WIDTH'($urandom);
            end
        end
        out_ready = (int'($urandom_range(99)) < pr);
        repeat (n) step();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        mask      = '0;
        p_valid   = 0;
        p_drop    = 0;
        p_ready   = 0;
        p_rst     = 0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            rd[i]    = '0;
            waits[i] = 0;
        end
        @(posedge clk);
        #1;
        m_last  = N_REQ - 1;
        m_valid = 1'b0;
        m_data  = '0;
        m_grant = 0;
        rst     = 1'b0;

        run_phase(4'b1111, 100, 0, 100, 0, 12);  // full rotation 0,1,2,3,0,...
        run_phase(4'b0100, 100, 0, 100, 0, 6);   // lone requester wins every cycle
        run_phase(4'b1010, 100, 0, 0, 0, 5);     // stalled output must freeze
        run_phase(4'b1010, 100, 0, 100, 0, 4);
        run_phase(4'b1001, 100, 0, 100, 0, 6);   // wrap from 3 back to 0
        run_phase(4'b0000, 0, 0, 100, 0, 3);     // drain: out_valid drops, word holds
        run_phase(4'b1111, 100, 0, 0, 0, 3);     // fill and stall, then reset while full
        rst = 1'b1;
        step();
        run_phase(4'b1111, 100, 0, 100, 0, 4);
        run_phase(4'b1111, 60, 10, 60, 2, 3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
